// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit.
// MULDIV_MADD_EN enables the madd/maddu/msub/msubu accumulate ops.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MADD  = 3'b100,
    OP_MADDU = 3'b101,
    OP_MSUB  = 3'b110,
    OP_MSUBU = 3'b111
  } op_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  function automatic logic is_div(input logic [2:0] op);
    return op[2:1] == 2'b01;
  endfunction

  // Accumulate ops are only legal when the adder is built in.
  function automatic logic op_supported(input logic [2:0] op);
`ifdef MULDIV_MADD_EN
    return 1'b1;
`else
    return !op[2];
`endif
  endfunction

endpackage

// File: rtl/muldiv_core.sv
// Combinational datapath: product, quotient/remainder and HI/LO accumulate.
// Accumulate path exists only with MULDIV_MADD_EN defined.
module muldiv_core
  import muldiv_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [63:0] res,
  output logic        res_we
);

  logic        sgn;
  logic [63:0] prod_s, prod_u;
  logic        a_neg, b_neg;
  logic [31:0] ua, ub, ub_safe, uq, ur, q, r;

  assign sgn = !op[0];

  always_comb begin
    prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    prod_u = {32'b0, a} * {32'b0, b};
  end

  // Signed divide done on magnitudes, then sign-fixed: truncation toward zero.
  always_comb begin
    a_neg   = sgn & a[31];
    b_neg   = sgn & b[31];
    ua      = a_neg ? -a : a;
    ub      = b_neg ? -b : b;
    ub_safe = (ub == 32'd0) ? 32'd1 : ub;
    uq      = ua / ub_safe;
    ur      = ua % ub_safe;
    q       = (a_neg ^ b_neg) ? -uq : uq;
    r       = a_neg ? -ur : ur;
  end

`ifdef MULDIV_MADD_EN
  logic [63:0] prod, acc;
  always_comb begin
    prod = sgn ? prod_s : prod_u;
    acc  = op[1] ? ({hi, lo} - prod) : ({hi, lo} + prod);
  end
`else
  logic unused_acc;
  assign unused_acc = ^{hi, lo};
`endif

  always_comb begin
    res    = '0;
    res_we = 1'b0;
    case (op[2:1])
      2'b00: begin
        res    = sgn ? prod_s : prod_u;
        res_we = 1'b1;
      end
      2'b01: begin
        res    = {r, q};
        res_we = (b != 32'd0);
      end
      default: begin
`ifdef MULDIV_MADD_EN
        res    = acc;
        res_we = 1'b1;
`else
        res    = '0;
        res_we = 1'b0;
`endif
      end
    endcase
  end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle MIPS-style HI/LO multiply/divide unit: FSM, counter, HI/LO regs.
// MULDIV_MADD_EN adds madd/maddu/msub/msubu; otherwise those ops are no-ops.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic [1:0]  hilo_wr,
  input  logic        flush,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  state_e      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [63:0] res;
  logic        res_we;

  muldiv_core u_core (
    .op    (op_q),
    .a     (a_q),
    .b     (b_q),
    .hi    (hi_q),
    .lo    (lo_q),
    .res   (res),
    .res_we(res_we)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE: begin
        // Raw start blocks mthi/mtlo even when the op itself is unsupported.
        if (!flush) begin
          if (start) begin
            if (op_supported(op)) begin
              state_d = S_RUN;
              cnt_d   = is_div(op) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
              op_d    = op;
              a_d     = src_a;
              b_d     = src_b;
            end
          end else begin
            if (hilo_wr[1]) hi_d = src_a;
            if (hilo_wr[0]) lo_d = src_a;
          end
        end
      end
      S_RUN: begin
        if (flush) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CW'(1)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          if (res_we) {hi_d, lo_d} = res;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy  = (state_q == S_RUN);
  assign stall = busy | start;
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: arithmetic reference model checked every
// cycle, plus hand-computed literal expectations at key points.
module tb_muldiv_unit;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] src_a = '0, src_b = '0;
  logic [1:0]  hilo_wr = 2'b00;
  logic        flush = 1'b0;
  logic        busy, stall;
  logic [31:0] hi, lo;

  int tests = 0;
  int fails = 0;

  muldiv_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .src_a(src_a),
    .src_b(src_b), .hilo_wr(hilo_wr), .flush(flush), .busy(busy),
    .stall(stall), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [64:0] model_res(input logic [2:0] o, input logic [31:0] a,
                                            input logic [31:0] b, input logic [31:0] h,
                                            input logic [31:0] l);
    longint sa, sb, ua, ub, q, r;
    logic [63:0] acc;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    acc = {h, l};
    case (o)
      3'd0: return {1'b1, 64'(sa * sb)};
      3'd1: return {1'b1, 64'(ua * ub)};
      3'd2, 3'd3: begin
        if (b == 32'd0) return {1'b0, h, l};
        if (o == 3'd2) begin q = sa / sb; r = sa % sb; end
        else begin q = ua / ub; r = ua % ub; end
        return {1'b1, r[31:0], q[31:0]};
      end
      3'd4: return {1'b1, acc + 64'(sa * sb)};
      3'd5: return {1'b1, acc + 64'(ua * ub)};
      3'd6: return {1'b1, acc - 64'(sa * sb)};
      default: return {1'b1, acc - 64'(ua * ub)};
    endcase
  endfunction

  function automatic logic model_ok(input logic [2:0] o);
`ifdef MULDIV_MADD_EN
    return o == o;
`else
    return !o[2];
`endif
  endfunction

  int          m_left;
  logic [31:0] m_hi, m_lo;
  logic [64:0] m_pend;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_left <= 0;
      m_hi   <= '0;
      m_lo   <= '0;
      m_pend <= '0;
    end else if (m_left > 0) begin
      if (flush) m_left <= 0;
      else if (m_left == 1) begin
        m_left <= 0;
        if (m_pend[64]) begin
          m_hi <= m_pend[63:32];
          m_lo <= m_pend[31:0];
        end
      end else m_left <= m_left - 1;
    end else if (!flush) begin
      if (start) begin
        if (model_ok(op)) begin
          m_left <= (op == 3'd2 || op == 3'd3) ? DC : MC;
          m_pend <= model_res(op, src_a, src_b, m_hi, m_lo);
        end
      end else begin
        if (hilo_wr[1]) m_hi <= src_a;
        if (hilo_wr[0]) m_lo <= src_a;
      end
    end
  end

  always @(negedge clk) begin
    chk("busy_model", {31'b0, busy}, {31'b0, m_left > 0});
    chk("stall_model", {31'b0, stall}, {31'b0, (m_left > 0) | start});
    chk("hi_model", hi, m_hi);
    chk("lo_model", lo, m_lo);
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_idle(output int n);
    bit done;
    done = 1'b0;
    n = 0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (busy) n++;
      else done = 1'b1;
    end
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL timeout: busy still %b, required 0", busy);
    end
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       output int n);
    @(posedge clk); #1;
    start = 1'b1; op = o; src_a = a; src_b = b;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle(n);
  endtask

  task automatic mt(input logic [1:0] w, input logic [31:0] d);
    @(posedge clk); #1;
    hilo_wr = w; src_a = d;
    @(posedge clk); #1;
    hilo_wr = 2'b00;
    @(negedge clk);
  endtask

  int n;

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    @(posedge clk); #1 reset = 1'b1;

    issue(3'd0, 32'hFFFFFFFF, 32'd2, n);
    chk("mult_cycles", n, MC);
    chk("mult_hi", hi, 32'hFFFFFFFF);
    chk("mult_lo", lo, 32'hFFFFFFFE);
    issue(3'd1, 32'hFFFFFFFF, 32'd2, n);
    chk("multu_hi", hi, 32'h00000001);
    chk("multu_lo", lo, 32'hFFFFFFFE);

    issue(3'd2, 32'hFFFFFFF9, 32'd2, n);
    chk("div_cycles", n, DC);
    chk("div_lo", lo, 32'hFFFFFFFD);
    chk("div_hi", hi, 32'hFFFFFFFF);
    issue(3'd3, 32'd7, 32'd0, n);
    chk("div0_cycles", n, DC);
    chk("div0_lo", lo, 32'hFFFFFFFD);
    chk("div0_hi", hi, 32'hFFFFFFFF);
    issue(3'd2, 32'd7, 32'hFFFFFFFE, n);
    chk("div_negb_lo", lo, 32'hFFFFFFFD);
    chk("div_negb_hi", hi, 32'd1);
    issue(3'd2, 32'h80000000, 32'hFFFFFFFF, n);
    chk("div_ovf_lo", lo, 32'h80000000);
    issue(3'd3, 32'd100, 32'd7, n);
    chk("divu_lo", lo, 32'd14);
    chk("divu_hi", hi, 32'd2);

    mt(2'b10, 32'h12345678);
    chk("mthi", hi, 32'h12345678);
    mt(2'b01, 32'h9ABCDEF0);
    chk("mtlo", lo, 32'h9ABCDEF0);

    // mthi while busy is ignored
    @(posedge clk); #1;
    start = 1'b1; op = 3'd0; src_a = 32'd3; src_b = 32'd4;
    @(posedge clk); #1;
    start = 1'b0; hilo_wr = 2'b10; src_a = 32'hDEADBEEF;
    @(posedge clk); #1;
    hilo_wr = 2'b00;
    wait_idle(n);
    chk("busy_mthi_hi", hi, 32'd0);
    chk("busy_mthi_lo", lo, 32'd12);

    // flush in busy cycle 3
    @(posedge clk); #1;
    start = 1'b1; op = 3'd0; src_a = 32'd5; src_b = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_busy", {31'b0, busy}, 32'd0);
    repeat (8) @(negedge clk);
    chk("flush_lo", lo, 32'd12);

    // flush on the completion edge
    @(posedge clk); #1;
    start = 1'b1; op = 3'd1; src_a = 32'd7; src_b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flushc_busy", {31'b0, busy}, 32'd0);
    chk("flushc_lo", lo, 32'd12);

    // start wins over same-cycle hilo_wr
    @(posedge clk); #1;
    start = 1'b1; hilo_wr = 2'b11; op = 3'd0; src_a = 32'd2; src_b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0; hilo_wr = 2'b00;
    wait_idle(n);
    chk("startwin_hi", hi, 32'd0);
    chk("startwin_lo", lo, 32'd6);

    // back-to-back: new start in the first idle cycle
    #1;
    start = 1'b1; op = 3'd1; src_a = 32'd10; src_b = 32'd11;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("b2b_busy", {31'b0, busy}, 32'd1);
    wait_idle(n);
    chk("b2b_lo", lo, 32'd110);

    // accumulate ops
    mt(2'b10, 32'd0);
    mt(2'b01, 32'hFFFFFFFF);
    issue(3'd5, 32'd1, 32'd1, n);
`ifdef MULDIV_MADD_EN
    chk("maddu_cycles", n, MC);
    chk("maddu_hi", hi, 32'd1);
    chk("maddu_lo", lo, 32'd0);
    issue(3'd6, 32'd1, 32'd1, n);
    chk("msub_hi", hi, 32'd0);
    chk("msub_lo", lo, 32'hFFFFFFFF);
    issue(3'd4, 32'hFFFFFFFF, 32'd1, n);
    chk("madd_lo", lo, 32'hFFFFFFFE);
`else
    chk("maddu_nobusy", n, 0);
    chk("maddu_hi", hi, 32'd0);
    chk("maddu_lo", lo, 32'hFFFFFFFF);
`endif

    // reset mid-divide
    mt(2'b10, 32'hAAAA5555);
    @(posedge clk); #1;
    start = 1'b1; op = 3'd2; src_a = 32'd100; src_b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk); #2;
    reset = 1'b0;
    #1;
    chk("rstmid_busy", {31'b0, busy}, 32'd0);
    chk("rstmid_hi", hi, 32'd0);
    chk("rstmid_lo", lo, 32'd0);
    @(posedge clk); #1 reset = 1'b1;
    repeat (15) @(negedge clk);
    chk("rstpost_hi", hi, 32'd0);
    chk("rstpost_lo", lo, 32'd0);
    chk("rstpost_busy", {31'b0, busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, busy cycles for mult/multu/madd/maddu/msub/msubu.
REQ-002 SHALL have parameter DIV_CYCLES, default 10, busy cycles for div/divu.
REQ-003 SHALL have port clk  in  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset (low = reset asserted).
REQ-005 SHALL have port start  in  1  one-cycle request to begin the operation given by op.
REQ-006 SHALL have port op  in  3  000 mult, 001 multu, 010 div, 011 divu, 100 madd, 101 maddu, 110 msub, 111 msubu.
REQ-007 SHALL have port src_a  in  32  rs operand; also mthi/mtlo data.
REQ-008 SHALL have port src_b  in  32  rt operand.
REQ-009 SHALL have port hilo_wr  in  2  bit1 = mthi, bit0 = mtlo; writes src_a.
REQ-010 SHALL have port flush  in  1  cancels any in-flight operation (exception/eret).
REQ-011 SHALL have port busy  out  1  operation in flight.
REQ-012 SHALL have port stall  out  1  busy | start, combinational, for the issuing stage.
REQ-013 SHALL have ports hi, lo  out  32 each, current HI/LO register values.

Function
REQ-014 SHALL implement a 2-state FSM: IDLE, RUN; a down-counter holds remaining cycles.
REQ-015 IDLE with start=1 and flush=0 SHALL latch op, src_a, src_b, load counter with MULT_CYCLES or DIV_CYCLES, go to RUN; busy=1 from the next cycle.
REQ-016 RUN SHALL decrement the counter each cycle; on the edge where the counter reaches 1, SHALL write HI/LO and return to IDLE; busy therefore high for exactly N cycles.
REQ-017 mult/multu SHALL produce {HI,LO} = 64-bit signed/unsigned product of latched operands.
REQ-018 div/divu SHALL produce LO = quotient, HI = remainder, signed truncating toward zero (remainder sign = dividend sign) / unsigned.
REQ-019 Divide by zero SHALL leave HI/LO unchanged; timing identical to a normal divide.
REQ-020 madd/maddu SHALL produce {HI,LO} += product; msub/msubu SHALL produce {HI,LO} -= product; 64-bit, wrap-around, no overflow flag.
REQ-021 hilo_wr SHALL write HI and/or LO with src_a on the next edge only in IDLE with start=0 and flush=0.
REQ-022 start and hilo_wr in the same cycle: start SHALL win, hilo_wr ignored.
REQ-023 start or hilo_wr while busy SHALL be ignored; no state change.
REQ-024 flush SHALL force IDLE on the next edge, discard the in-flight result, keep HI/LO unchanged, and suppress a same-cycle start or hilo_wr.
REQ-025 flush on the completion edge SHALL discard the result (flush wins).
REQ-026 A new start SHALL be accepted in the first cycle with busy=0 after completion.

Reset
REQ-027 reset low SHALL asynchronously force IDLE, counter=0, busy=0, hi=0, lo=0, latched operands=0.
REQ-028 reset mid-operation SHALL abandon the operation; no HI/LO write after release.

Configuration
REQ-029 Macro MULDIV_MADD_EN defined: op 100-111 SHALL operate per REQ-020.
REQ-030 MULDIV_MADD_EN undefined: op 100-111 SHALL be treated as no-op (start ignored, busy stays 0, HI/LO unchanged) and no accumulate adder SHALL be synthesized.

Structure
REQ-031 Shared package SHALL hold the op encodings, MULT_CYCLES/DIV_CYCLES defaults, and the FSM state type.
REQ-032 Datapath (product/quotient/accumulate) SHALL be one sub-module muldiv_core; FSM, counter, HI/LO registers stay in muldiv_unit.

Verification
REQ-033 mult src_a=0xFFFFFFFF, src_b=2 -> busy high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE; multu same operands -> HI=0x00000001, LO=0xFFFFFFFE.
REQ-034 div src_a=-7 (0xFFFFFFF9), src_b=2 -> busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu 7/0 -> HI/LO unchanged after 10 cycles.
REQ-035 mthi 0x12345678 then mtlo 0x9ABCDEF0 in IDLE -> hi/lo update next edge; mthi asserted during busy -> HI unchanged.
REQ-036 start mult, flush at busy cycle 3 -> busy=0 next cycle, HI/LO hold prior values; flush on completion edge -> no write.
REQ-037 With MULDIV_MADD_EN: HI=0, LO=0xFFFFFFFF, maddu 1*1 -> HI=1, LO=0; without macro same stimulus -> busy never rises, HI/LO unchanged.
REQ-038 reset low during div cycle 4 -> busy=0, hi=lo=0 immediately; no write after release.
